rs232_uart: RTL and testbench

Memory-mapped 8N1 UART peripheral on the processor's simple control bus, decoded at 0x2000_0000–0x2000_000F by the system interconnect. Accepts byte writes for serial transmission on `txd` and buffers one received byte from `rxd`. Completion is signalled with a one-cycle `ctrl_done` pulse per bus access, which the interconnect turns into `mem_ready`.

---
 rtl/rs232_pkg.sv | 32 +++
 rtl/rs232_rx.sv | 126 ++++++++++++
 rtl/rs232_uart.sv | 187 ++++++++++++++++++
 tb/tb_rs232_uart.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/rs232_pkg.sv
// Shared definitions for the rs232_uart peripheral: register offsets,
// status bit positions, FSM state encodings and the baud divider helper.
package rs232_pkg;

    localparam logic [1:0] REG_DATA   = 2'd0;
    localparam logic [1:0] REG_STATUS = 2'd1;

    localparam int unsigned STAT_RXV    = 0;
    localparam int unsigned STAT_TXBUSY = 1;
    localparam int unsigned STAT_OVR    = 2;

    typedef enum logic [1:0] {
        TX_IDLE,
        TX_START,
        TX_DATA,
        TX_STOP
    } tx_state_e;

    typedef enum logic [1:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_STOP
    } rx_state_e;

    // Bit period in clocks, rounded to nearest.
    function automatic int unsigned baud_div(input int unsigned clk_hz,
                                             input int unsigned baud);
        return (clk_hz + baud / 2) / baud;
    endfunction

endpackage

// File: rtl/rs232_rx.sv
// 8N1 receiver: input synchronizer, bit-centre sampling FSM and the
// single-byte receive buffer with its valid and overrun flags.
module rs232_rx
    import rs232_pkg::*;
#(
    parameter int unsigned DIV = 434
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       rxd_i,
    input  logic       clr_rxv_i,
    input  logic       clr_ovr_i,
    output logic [7:0] byte_o,
    output logic       rxv_o,
    output logic       ovr_o
);

    localparam int unsigned    CW       = $clog2(DIV);
    localparam logic [CW-1:0] BIT_END  = CW'(DIV - 1);
    localparam logic [CW-1:0] HALF_END = CW'(DIV / 2 - 1);

    logic [1:0]    sync_q;
    logic          prev_q;
    logic          rxd_s;
    rx_state_e     state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0]    bit_q, bit_d;
    logic [7:0]    shift_q, shift_d;
    logic [7:0]    byte_q, byte_d;
    logic          rxv_q, rxv_d;
    logic          ovr_q, ovr_d;
    logic          frame_ok;

    assign rxd_s = sync_q[1];

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sync_q  <= '1;
            prev_q  <= 1'b1;
            state_q <= RX_IDLE;
            cnt_q   <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            byte_q  <= '0;
            rxv_q   <= 1'b0;
            ovr_q   <= 1'b0;
        end else begin
            sync_q  <= {sync_q[0], rxd_i};
            prev_q  <= rxd_s;
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            byte_q  <= byte_d;
            rxv_q   <= rxv_d;
            ovr_q   <= ovr_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        bit_d    = bit_q;
        shift_d  = shift_q;
        byte_d   = byte_q;
        rxv_d    = rxv_q;
        ovr_d    = ovr_q;
        frame_ok = 1'b0;

        unique case (state_q)
            RX_IDLE: begin
                // Edge, not level: a line stuck low after a framing error must not retrigger.
                if (prev_q && !rxd_s) begin
                    state_d = RX_START;
                    cnt_d   = '0;
                end
            end
            RX_START: begin
                if (cnt_q == HALF_END) begin
                    cnt_d   = '0;
                    bit_d   = '0;
                    state_d = rxd_s ? RX_IDLE : RX_DATA;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            RX_DATA: begin
                if (cnt_q == BIT_END) begin
                    cnt_d   = '0;
                    shift_d = {rxd_s, shift_q[7:1]};
                    if (bit_q == 3'd7) begin
                        state_d = RX_STOP;
                    end else begin
                        bit_d = bit_q + 3'd1;
                    end
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            RX_STOP: begin
                if (cnt_q == BIT_END) begin
                    cnt_d    = '0;
                    state_d  = RX_IDLE;
                    frame_ok = rxd_s;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            default: state_d = RX_IDLE;
        endcase

        if (clr_rxv_i) rxv_d = 1'b0;
        if (clr_ovr_i) ovr_d = 1'b0;
        // A completing frame wins over a same-cycle read clear.
        if (frame_ok) begin
            byte_d = shift_q;
            rxv_d  = 1'b1;
            if (rxv_q) ovr_d = 1'b1;
        end
    end

    assign byte_o = byte_q;
    assign rxv_o  = rxv_q;
    assign ovr_o  = ovr_q;

endmodule

// File: rtl/rs232_uart.sv
// Memory-mapped 8N1 UART: bus decode with one-shot access handshake,
// transmit shift FSM, and the rs232_rx receiver.
module rs232_uart
    import rs232_pkg::*;
#(
    parameter int unsigned CLOCK_FREQ_HZ = 50000000,
    parameter int unsigned BAUD          = 115200
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        ctrl_wr,
    input  logic        ctrl_rd,
    input  logic [31:0] ctrl_addr,
    input  logic [31:0] ctrl_wdat,
    output logic [31:0] ctrl_rdat,
    output logic        ctrl_done,
    input  logic        rxd,
    output logic        txd
);

    localparam int unsigned    DIV     = baud_div(CLOCK_FREQ_HZ, BAUD);
    localparam int unsigned    CW      = $clog2(DIV);
    localparam logic [CW-1:0] BIT_END = CW'(DIV - 1);

    logic          done_q, done_d;
    logic          acc_q, acc_d;
    logic [31:0]   rdat_q, rdat_d;
    logic          txld_q, txld_d;
    tx_state_e     tx_state_q, tx_state_d;
    logic [CW-1:0] tx_cnt_q, tx_cnt_d;
    logic [2:0]    tx_bit_q, tx_bit_d;
    logic [7:0]    tx_shift_q, tx_shift_d;
    logic          txd_q, txd_d;

    logic [1:0]    reg_sel;
    logic          tx_busy;
    logic          can_start;
    logic          wr_go;
    logic          rd_go;
    logic [31:0]   status;
    logic          clr_rxv;
    logic          clr_ovr;
    logic [7:0]    rx_byte;
    logic          rxv;
    logic          ovr;
    logic          unused_bits;

    assign unused_bits = ^{ctrl_addr[31:4], ctrl_addr[1:0], ctrl_wdat[31:8]};

    rs232_rx #(
        .DIV(DIV)
    ) u_rx (
        .clk_i    (clk),
        .rst_ni   (resetn),
        .rxd_i    (rxd),
        .clr_rxv_i(clr_rxv),
        .clr_ovr_i(clr_ovr),
        .byte_o   (rx_byte),
        .rxv_o    (rxv),
        .ovr_o    (ovr)
    );

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            done_q     <= 1'b0;
            acc_q      <= 1'b0;
            rdat_q     <= '0;
            txld_q     <= 1'b0;
            tx_state_q <= TX_IDLE;
            tx_cnt_q   <= '0;
            tx_bit_q   <= '0;
            tx_shift_q <= '0;
            txd_q      <= 1'b1;
        end else begin
            done_q     <= done_d;
            acc_q      <= acc_d;
            rdat_q     <= rdat_d;
            txld_q     <= txld_d;
            tx_state_q <= tx_state_d;
            tx_cnt_q   <= tx_cnt_d;
            tx_bit_q   <= tx_bit_d;
            tx_shift_q <= tx_shift_d;
            txd_q      <= txd_d;
        end
    end

    assign reg_sel   = ctrl_addr[3:2];
    assign tx_busy   = (tx_state_q != TX_IDLE) || txld_q;
    // The done cycle itself also blocks, since acc_q only rises one cycle later.
    assign can_start = !acc_q && !done_q;
    assign wr_go     = ctrl_wr && can_start && ((reg_sel != REG_DATA) || !tx_busy);
    assign rd_go     = ctrl_rd && !ctrl_wr && can_start;

    always_comb begin
        status              = '0;
        status[STAT_RXV]    = rxv;
        status[STAT_TXBUSY] = tx_busy;
        status[STAT_OVR]    = ovr;

        done_d  = wr_go || rd_go;
        txld_d  = wr_go && (reg_sel == REG_DATA);
        rdat_d  = rdat_q;
        clr_rxv = 1'b0;
        clr_ovr = 1'b0;

        if (done_q) begin
            acc_d = 1'b1;
        end else if (!ctrl_rd && !ctrl_wr) begin
            acc_d = 1'b0;
        end else begin
            acc_d = acc_q;
        end

        if (rd_go) begin
            case (reg_sel)
                REG_DATA: begin
                    rdat_d  = {24'd0, rx_byte};
                    clr_rxv = 1'b1;
                end
                REG_STATUS: begin
                    rdat_d  = status;
                    clr_ovr = 1'b1;
                end
                default: rdat_d = '0;
            endcase
        end
    end

    always_comb begin
        tx_state_d = tx_state_q;
        tx_cnt_d   = tx_cnt_q;
        tx_bit_d   = tx_bit_q;
        tx_shift_d = tx_shift_q;
        txd_d      = txd_q;

        unique case (tx_state_q)
            TX_IDLE: begin
                if (txld_q) begin
                    tx_state_d = TX_START;
                    tx_cnt_d   = '0;
                    txd_d      = 1'b0;
                end else if (txld_d) begin
                    tx_shift_d = ctrl_wdat[7:0];
                end
            end
            TX_START: begin
                if (tx_cnt_q == BIT_END) begin
                    tx_cnt_d   = '0;
                    tx_bit_d   = '0;
                    tx_state_d = TX_DATA;
                    txd_d      = tx_shift_q[0];
                end else begin
                    tx_cnt_d = tx_cnt_q + CW'(1);
                end
            end
            TX_DATA: begin
                if (tx_cnt_q == BIT_END) begin
                    tx_cnt_d = '0;
                    if (tx_bit_q == 3'd7) begin
                        tx_state_d = TX_STOP;
                        txd_d      = 1'b1;
                    end else begin
                        tx_bit_d   = tx_bit_q + 3'd1;
                        tx_shift_d = {1'b0, tx_shift_q[7:1]};
                        txd_d      = tx_shift_q[1];
                    end
                end else begin
                    tx_cnt_d = tx_cnt_q + CW'(1);
                end
            end
            TX_STOP: begin
                if (tx_cnt_q == BIT_END) begin
                    tx_cnt_d   = '0;
                    tx_state_d = TX_IDLE;
                end else begin
                    tx_cnt_d = tx_cnt_q + CW'(1);
                end
            end
            default: tx_state_d = TX_IDLE;
        endcase
    end

    assign ctrl_done = done_q;
    assign ctrl_rdat = rdat_q;
    assign txd       = txd_q;

endmodule

// File: tb/tb_rs232_uart.sv
// Directed bench for rs232_uart: TX waveform and stall, RX vector table,
// held-read single completion, and asynchronous reset mid-frame.
module tb_rs232_uart;

    localparam int unsigned DIV = 434;

    typedef enum int {OP_RX, OP_GLITCH, OP_RD_STAT, OP_RD_DATA} op_e;
    typedef struct {
        op_e         op;
        logic [7:0]  b;
        logic        stop;
        logic [31:0] exp;
        int          hold;
    } vec_t;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        ctrl_wr = 1'b0;
    logic        ctrl_rd = 1'b0;
    logic [31:0] ctrl_addr = '0;
    logic [31:0] ctrl_wdat = '0;
    logic [31:0] ctrl_rdat;
    logic        ctrl_done;
    logic        rxd = 1'b1;
    logic        txd;

    int checks = 0;
    int errors = 0;

    vec_t        vecs[$];
    logic [31:0] rd;
    int          lat;
    int          extra;
    time         t_dn;
    time         t_stop1;
    time         t_done2;
    time         t_fall;
    time         t_dummy;

    always #5 clk = ~clk;

    rs232_uart #(
        .CLOCK_FREQ_HZ(50000000),
        .BAUD         (115200)
    ) dut (
        .clk      (clk),
        .resetn   (resetn),
        .ctrl_wr  (ctrl_wr),
        .ctrl_rd  (ctrl_rd),
        .ctrl_addr(ctrl_addr),
        .ctrl_wdat(ctrl_wdat),
        .ctrl_rdat(ctrl_rdat),
        .ctrl_done(ctrl_done),
        .rxd      (rxd),
        .txd      (txd)
    );

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
        end
    endtask

    // lat counts falling edges until ctrl_done; 2 means done in the cycle after the request.
    task automatic bus_access(input bit wr, input logic [1:0] reg_idx, input logic [7:0] wd,
                              input int hold, output logic [31:0] rdat, output int lat_o,
                              output int anomalies, output time t_done_o);
        bit got;
        @(posedge clk);
        #1;
        ctrl_addr = 32'h2000_0000 | {28'd0, reg_idx, 2'b00};
        ctrl_wdat = {24'hABCDEF, wd};
        ctrl_wr   = wr;
        ctrl_rd   = !wr;
        lat_o     = 0;
        got       = 1'b0;
        anomalies = 0;
        while (!got && lat_o < 6000) begin
            @(negedge clk);
            lat_o++;
            got = ctrl_done;
        end
        if (!got) lat_o = -1;
        t_done_o = $time;
        rdat = ctrl_rdat;
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            if (ctrl_done) anomalies++;
            if (ctrl_rdat !== rdat) anomalies++;
        end
        @(posedge clk);
        #1;
        ctrl_wr = 1'b0;
        ctrl_rd = 1'b0;
    endtask

    task automatic rd_check(input string name, input logic [1:0] r, input logic [31:0] exp,
                            input int hold);
        logic [31:0] v;
        int          l;
        int          x;
        time         t;
        bus_access(1'b0, r, 8'h00, hold, v, l, x, t);
        check({name, " rdat"}, v, exp);
        check({name, " latency"}, l, 2);
        if (hold > 0) check({name, " single done"}, x, 0);
    endtask

    // Samples every clock of a frame; pre = samples of the start bit already taken.
    task automatic check_frame(input logic [7:0] b, input string name, input int pre,
                               output time t_last);
        logic [9:0] bits;
        int         bad;
        bits = {1'b1, b, 1'b0};
        for (int k = 0; k < 10; k++) begin
            bad = 0;
            for (int s = (k == 0) ? pre : 0; s < int'(DIV); s++) begin
                @(negedge clk);
                if (txd !== bits[k]) bad++;
            end
            checks++;
            if (bad != 0) begin
                errors++;
                $display("FAIL %s bit%0d: %0d of %0d samples wrong, want %0b",
                         name, k, bad, DIV, bits[k]);
            end
        end
        t_last = $time;
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stop);
        logic [9:0] bits;
        bits = {stop, b, 1'b0};
        @(posedge clk);
        #1;
        for (int k = 0; k < 10; k++) begin
            rxd = bits[k];
            repeat (DIV) @(posedge clk);
            #1;
        end
        rxd = 1'b1;
        repeat (60) @(posedge clk);
    endtask

    task automatic send_glitch();
        @(posedge clk);
        #1;
        rxd = 1'b0;
        repeat (100) @(posedge clk);
        #1;
        rxd = 1'b1;
        repeat (400) @(posedge clk);
    endtask

    initial begin
        // Reset state
        repeat (5) @(posedge clk);
        @(negedge clk);
        check("reset txd", txd, 1);
        check("reset done", ctrl_done, 0);
        check("reset rdat", ctrl_rdat, 0);
        @(posedge clk);
        #1;
        resetn = 1'b1;
        repeat (3) @(posedge clk);

        // TX 0x55 from idle, then 0xA3 written mid-frame must stall
        bus_access(1'b1, 2'd0, 8'h55, 0, rd, lat, extra, t_dn);
        check("tx 55 write latency", lat, 2);
        fork
            begin : thr_a
                int w;
                check_frame(8'h55, "tx 55", 0, t_stop1);
                w = 0;
                do begin
                    @(negedge clk);
                    w++;
                end while (txd !== 1'b0 && w < 20);
                t_fall = $time;
                check("tx A3 start seen", txd, 0);
                check_frame(8'hA3, "tx A3", 1, t_dummy);
            end
            begin : thr_b
                logic [31:0] v;
                int          l;
                int          x;
                repeat (2000) @(posedge clk);
                rd_check("status mid-frame", 2'd1, 32'h2, 0);
                bus_access(1'b1, 2'd0, 8'hA3, 0, v, l, x, t_done2);
                check("tx A3 write completed", (l > 0), 1);
            end
        join
        check("A3 done not before stop end", (t_done2 > t_stop1), 1);
        check("A3 done promptly after idle", (t_done2 <= t_stop1 + 30), 1);
        check("A3 start bit cycle after done", 32'(t_fall - t_done2), 10);
        rd_check("status after tx", 2'd1, 32'h0, 0);

        // RX vectors
        vecs.push_back('{OP_RD_STAT, 8'h00, 1'b1, 32'h0,  0});
        vecs.push_back('{OP_RD_DATA, 8'h00, 1'b1, 32'h0,  0});
        vecs.push_back('{OP_RX,      8'h4B, 1'b1, 32'h0,  0});
        vecs.push_back('{OP_RD_STAT, 8'h00, 1'b1, 32'h1,  0});
        vecs.push_back('{OP_RD_DATA, 8'h00, 1'b1, 32'h4B, 3});
        vecs.push_back('{OP_RD_STAT, 8'h00, 1'b1, 32'h0,  0});
        vecs.push_back('{OP_RX,      8'h11, 1'b1, 32'h0,  0});
        vecs.push_back('{OP_RX,      8'h22, 1'b1, 32'h0,  0});
        vecs.push_back('{OP_RD_STAT, 8'h00, 1'b1, 32'h5,  0});
        vecs.push_back('{OP_RD_DATA, 8'h00, 1'b1, 32'h22, 0});
        vecs.push_back('{OP_RD_STAT, 8'h00, 1'b1, 32'h0,  0});
        vecs.push_back('{OP_RX,      8'h3C, 1'b0, 32'h0,  0});
        vecs.push_back('{OP_RD_STAT, 8'h00, 1'b1, 32'h0,  0});
        vecs.push_back('{OP_GLITCH,  8'h00, 1'b1, 32'h0,  0});
        vecs.push_back('{OP_RD_STAT, 8'h00, 1'b1, 32'h0,  0});
        vecs.push_back('{OP_RD_DATA, 8'h00, 1'b1, 32'h22, 0});
        vecs.push_back('{OP_RX,      8'hA5, 1'b1, 32'h0,  0});
        vecs.push_back('{OP_RD_STAT, 8'h00, 1'b1, 32'h1,  2});
        vecs.push_back('{OP_RD_DATA, 8'h00, 1'b1, 32'hA5, 0});

        foreach (vecs[i]) begin
            case (vecs[i].op)
                OP_RX:      send_frame(vecs[i].b, vecs[i].stop);
                OP_GLITCH:  send_glitch();
                OP_RD_STAT: rd_check($sformatf("v%0d status", i), 2'd1, vecs[i].exp, vecs[i].hold);
                OP_RD_DATA: rd_check($sformatf("v%0d data", i), 2'd0, vecs[i].exp, vecs[i].hold);
                default: ;
            endcase
        end

        // Unmapped offset reads zero
        rd_check("reg2 read", 2'd2, 32'h0, 0);

        // Reset in the middle of an all-zero frame forces txd high without a clock edge
        bus_access(1'b1, 2'd0, 8'h00, 0, rd, lat, extra, t_dn);
        repeat (1000) @(negedge clk);
        check("tx 00 mid-frame low", txd, 0);
        #2;
        resetn = 1'b0;
        #1;
        check("async reset txd", txd, 1);
        check("async reset done", ctrl_done, 0);
        @(posedge clk);
        #1;
        resetn = 1'b1;
        repeat (3) @(posedge clk);
        rd_check("status after reset", 2'd1, 32'h0, 0);
        rd_check("data after reset", 2'd0, 32'h0, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
